// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle FWD/ADD/AND/OR, bit-serial shifts, shift-add multiply.
// START/BUSY/DONE handshake with registered RESULT and CARRY.
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t               state;
  logic [1:0]           shop;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   prod;

  logic [WIDTH-1:0]     sh_next;
  logic                 sh_out;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH:0]       sum;
  logic [SHAMT_W-1:0]   shamt;

  assign sum   = {1'b0, DATA1} + {1'b0, DATA2};
  assign shamt = DATA2[SHAMT_W-1:0];
  assign ZERO  = (RESULT == '0);

  // One-bit shift step; shop holds SELECT[1:0] (00 SLL, 01 SRL, 10 SRA).
  always_comb begin
    sh_next = acc;
    sh_out  = 1'b0;
    case (shop)
      2'b00: begin
        sh_next = {acc[WIDTH-2:0], 1'b0};
        sh_out  = acc[WIDTH-1];
      end
      2'b01: begin
        sh_next = {1'b0, acc[WIDTH-1:1]};
        sh_out  = acc[0];
      end
      default: begin
        sh_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
        sh_out  = acc[0];
      end
    endcase
  end

  // acc doubles as the multiplier shift register during MUL.
  assign prod_next = prod + (acc[0] ? mcand : '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      shop   <= '0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      prod   <= '0;
      RESULT <= '0;
      CARRY  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            case (SELECT)
              3'b000: begin
                RESULT <= DATA2;
                CARRY  <= 1'b0;
                DONE   <= 1'b1;
              end
              3'b001: begin
                RESULT <= sum[WIDTH-1:0];
                CARRY  <= sum[WIDTH];
                DONE   <= 1'b1;
              end
              3'b010: begin
                RESULT <= DATA1 & DATA2;
                CARRY  <= 1'b0;
                DONE   <= 1'b1;
              end
              3'b011: begin
                RESULT <= DATA1 | DATA2;
                CARRY  <= 1'b0;
                DONE   <= 1'b1;
              end
              3'b111: begin
                state <= MUL;
                BUSY  <= 1'b1;
                count <= CNT_W'(WIDTH);
                acc   <= DATA2;
                mcand <= {{WIDTH{1'b0}}, DATA1};
                prod  <= '0;
              end
              default: begin
                if (shamt == '0) begin
                  RESULT <= DATA1;
                  CARRY  <= 1'b0;
                  DONE   <= 1'b1;
                end else begin
                  state <= SHIFT;
                  BUSY  <= 1'b1;
                  shop  <= SELECT[1:0];
                  count <= {1'b0, shamt};
                  acc   <= DATA1;
                end
              end
            endcase
          end
        end
        SHIFT: begin
          acc   <= sh_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            RESULT <= sh_next;
            CARRY  <= sh_out;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end
        end
        MUL: begin
          prod  <= prod_next;
          mcand <= mcand << 1;
          acc   <= acc >> 1;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            RESULT <= prod_next[WIDTH-1:0];
            CARRY  <= |prod_next[2*WIDTH-1:WIDTH];
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with immediate-assertion checks.
module tb_alu_seq;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic [2:0] SELECT;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       CARRY;
  logic       BUSY;
  logic       DONE;

  int tests  = 0;
  int failed = 0;
  int dones;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
    .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    START  = 1'b1;
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
  endtask

  initial begin
    RESET_N = 1'b1;
    START   = 1'b0;
    SELECT  = 3'b000;
    DATA1   = 8'h00;
    DATA2   = 8'h00;
    #2 RESET_N = 1'b0;
    repeat (3) tick();
    chk("rst_result", RESULT, 8'h00);
    chk("rst_zero",   ZERO,   1'b1);
    chk("rst_carry",  CARRY,  1'b0);
    chk("rst_busy",   BUSY,   1'b0);
    chk("rst_done",   DONE,   1'b0);
    RESET_N = 1'b1;

    // ADD 5+3, then back-to-back ADD and OR
    issue(3'b001, 8'h05, 8'h03);
    tick();
    chk("add1_result", RESULT, 8'h08);
    chk("add1_done",   DONE,   1'b1);
    chk("add1_busy",   BUSY,   1'b0);
    issue(3'b001, 8'hF0, 8'h20);
    tick();
    chk("add2_result", RESULT, 8'h10);
    chk("add2_carry",  CARRY,  1'b1);
    chk("add2_zero",   ZERO,   1'b0);
    chk("add2_done",   DONE,   1'b1);
    issue(3'b011, 8'h0F, 8'hF0);
    tick();
    chk("or_result", RESULT, 8'hFF);
    chk("or_carry",  CARRY,  1'b0);
    chk("or_done",   DONE,   1'b1);
    START = 1'b0;
    tick();
    chk("idle_done",  DONE,   1'b0);
    chk("idle_hold",  RESULT, 8'hFF);

    // SRA 0x90 by 3
    issue(3'b110, 8'h90, 8'h03);
    tick();
    START = 1'b0;
    chk("sra_e0_busy", BUSY, 1'b1);
    chk("sra_e0_done", DONE, 1'b0);
    for (int k = 1; k < 3; k++) begin
      tick();
      chk("sra_mid_busy", BUSY, 1'b1);
      chk("sra_mid_done", DONE, 1'b0);
    end
    tick();
    chk("sra_result", RESULT, 8'hF2);
    chk("sra_carry",  CARRY,  1'b0);
    chk("sra_done",   DONE,   1'b1);
    chk("sra_busy",   BUSY,   1'b0);
    tick();
    chk("sra_done_fall", DONE, 1'b0);

    // SLL 0x81 by 1
    issue(3'b100, 8'h81, 8'h01);
    tick();
    START = 1'b0;
    chk("sll_e0_busy", BUSY, 1'b1);
    tick();
    chk("sll_result", RESULT, 8'h02);
    chk("sll_carry",  CARRY,  1'b1);
    chk("sll_done",   DONE,   1'b1);

    // SRL 0x81 by 0 completes immediately
    issue(3'b101, 8'h81, 8'h00);
    tick();
    START = 1'b0;
    chk("srl0_result", RESULT, 8'h81);
    chk("srl0_carry",  CARRY,  1'b0);
    chk("srl0_done",   DONE,   1'b1);
    chk("srl0_busy",   BUSY,   1'b0);

    // MUL 13 x 11
    issue(3'b111, 8'd13, 8'd11);
    tick();
    START = 1'b0;
    chk("mul1_e0_busy", BUSY, 1'b1);
    dones = 0;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (DONE) dones++;
    end
    chk("mul1_early_done", dones, 0);
    tick();
    chk("mul1_result", RESULT, 8'h8F);
    chk("mul1_carry",  CARRY,  1'b0);
    chk("mul1_done",   DONE,   1'b1);
    chk("mul1_busy",   BUSY,   1'b0);

    // MUL 0x10 x 0x10 overflows
    issue(3'b111, 8'h10, 8'h10);
    tick();
    START = 1'b0;
    repeat (8) tick();
    chk("mul2_result", RESULT, 8'h00);
    chk("mul2_zero",   ZERO,   1'b1);
    chk("mul2_carry",  CARRY,  1'b1);
    chk("mul2_done",   DONE,   1'b1);

    // START with ADD during a running MUL is ignored
    issue(3'b111, 8'h0F, 8'h03);
    tick();
    START = 1'b0;
    dones = 0;
    tick();
    issue(3'b001, 8'h01, 8'h01);
    tick();
    START = 1'b0;
    if (DONE) dones++;
    for (int k = 3; k < 8; k++) begin
      tick();
      if (DONE) dones++;
    end
    tick();
    chk("mul3_result", RESULT, 8'h2D);
    chk("mul3_done",   DONE,   1'b1);
    if (DONE) dones++;
    repeat (3) begin
      tick();
      if (DONE) dones++;
    end
    chk("mul3_done_count", dones, 1);
    chk("mul3_hold", RESULT, 8'h2D);

    // Asynchronous reset at E4 of a MUL
    issue(3'b111, 8'hFF, 8'hFF);
    tick();
    START = 1'b0;
    repeat (4) tick();
    chk("mul4_busy_e4", BUSY, 1'b1);
    RESET_N = 1'b0;
    #1;
    chk("arst_result", RESULT, 8'h00);
    chk("arst_zero",   ZERO,   1'b1);
    chk("arst_busy",   BUSY,   1'b0);
    chk("arst_done",   DONE,   1'b0);
    #1 RESET_N = 1'b1;
    dones = 0;
    repeat (6) begin
      tick();
      if (DONE || BUSY) dones++;
    end
    chk("arst_no_done", dones, 0);
    issue(3'b000, 8'h00, 8'h5A);
    tick();
    START = 1'b0;
    chk("fwd_result", RESULT, 8'h5A);
    chk("fwd_done",   DONE,   1'b1);
    chk("fwd_carry",  CARRY,  1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU, the next generation of the 8-bit combinational ALU in the CPU datapath. It keeps the FWD/ADD/AND/OR opcode encoding and adds logical and arithmetic shifts plus an unsigned multiply, using a START/BUSY/DONE handshake with the control unit. Results and flags are registered. Single-cycle ops complete in one clock; shifts run one bit per clock and multiply runs one partial product per clock.

## Interface
- WIDTH, 8, operand/result width; power of two, 4..32
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)
- CLK  input  1  clock, rising edge
- RESET_N  input  1  asynchronous, active-low reset
- START  input  1  request; sampled only while BUSY=0
- SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA, 111 MUL
- DATA1  input  WIDTH  operand A (value to shift, multiplicand)
- DATA2  input  WIDTH  operand B (FWD source, shift amount in DATA2[SHAMT_W-1:0], multiplier)
- RESULT  output  WIDTH  registered result; holds its value until the next completion
- ZERO  output  1  1 when RESULT==0, decoded from the RESULT register
- CARRY  output  1  registered flag, updated at completion (see Operation)
- BUSY  output  1  high while a multi-cycle op is in progress
- DONE  output  1  one-cycle pulse: RESULT/CARRY just updated

## Operation
- Reset state: RESULT=0, ZERO=1, CARRY=0, BUSY=0, DONE=0, FSM=IDLE, internal count/accumulators 0.
- FSM states: IDLE, SHIFT, MUL.
- Accept: at a rising edge with START=1 and BUSY=0. SELECT, DATA1 and DATA2 are latched at that edge. Later changes on the inputs are ignored.
- START while BUSY=1 is ignored and produces no queueing.
- FWD/AND/OR: RESULT = DATA2, DATA1&DATA2 or DATA1|DATA2; CARRY=0. FSM stays in IDLE.
- ADD: RESULT = (DATA1+DATA2) mod 2^WIDTH; CARRY = bit WIDTH of the sum. Subtraction is done upstream by two's-complement negation.
- Shifts, with n = DATA2[SHAMT_W-1:0]:
  - n=0 completes like a single-cycle op: RESULT=DATA1, CARRY=0.
  - n>0: go to SHIFT with count=n and acc=DATA1. Each clock shifts one bit and decrements count. At count 1→0, write RESULT and go to IDLE.
  - SLL fills with 0. SRL fills with 0. SRA replicates acc[WIDTH-1].
  - CARRY = the last bit shifted out.
- MUL: unsigned shift-add over a 2*WIDTH-bit product register, one multiplier bit per clock (LSB first), WIDTH iterations in state MUL.
  - RESULT = product[WIDTH-1:0].
  - CARRY = |product[2*WIDTH-1:WIDTH] (overflow).
- Every completion writes RESULT and CARRY and pulses DONE for exactly one cycle. The FSM returns to IDLE in that same edge.
- All 8 SELECT codes are defined. There is no X output.

## Timing
- E0 is the accepting edge. Ek is the k-th edge after E0.
- Single-cycle ops and shifts with n=0: RESULT, CARRY and DONE=1 update at E0. BUSY stays 0.
- Shift with n>0:
  - BUSY=1 from E0.
  - RESULT, CARRY and DONE=1 update at En, and BUSY=0 at En.
  - Latency is n+1 cycles counted from the START cycle.
- MUL: BUSY=1 from E0; completion at E_WIDTH.
- DONE falls at the edge after it rises, unless a new single-cycle op is accepted at that edge.
- Back-to-back operation:
  - START held high in the DONE cycle is accepted, since BUSY=0 there.
  - Consecutive single-cycle ops give one result per clock, with DONE held high.
- ZERO follows RESULT combinationally with no added cycle.
- RESET_N low at any time, including mid-SHIFT or mid-MUL:
  - All outputs and state return to reset values immediately (asynchronous). The op is aborted with no DONE.
  - The first START is accepted at the first rising edge after RESET_N deasserts.

## Test plan
- Reset: hold RESET_N=0 → RESULT=0x00, ZERO=1, CARRY=0, BUSY=0, DONE=0. Release it, then send ADD 0x05+0x03 → RESULT=0x08 and DONE at E0.
- ADD 0xF0+0x20 → RESULT=0x10, CARRY=1, ZERO=0 at E0. Next cycle OR 0x0F|0xF0 → 0xFF, CARRY=0, DONE high for both cycles.
- Shifts (WIDTH=8):
  - SRA 0x90 by 3 → 0xF2, CARRY=0, DONE at E3, BUSY high E0..E3.
  - SLL 0x81 by 1 → 0x02, CARRY=1 at E1.
  - SRL 0x81 by 0 → 0x81 at E0 with BUSY never high.
- MUL 13×11 → RESULT=0x8F, CARRY=0, DONE at E8. MUL 0x10×0x10 → RESULT=0x00, ZERO=1, CARRY=1.
- START with ADD pulsed at E2 of a running MUL → ignored. The MUL result is unchanged and there is exactly one DONE pulse.
- RESET_N pulsed low at E4 of a MUL → immediate reset values and no DONE. A FWD 0x5A issued after release → RESULT=0x5A at its E0.
